n64_tx_serializer: RTL

N64_TX_SERIALIZER -- requirements
Module: n64_tx_serializer

---
 rtl/n64_pkg.sv | 27 ++
 rtl/n64_quarter_tick.sv | 36 +++
 rtl/n64_tx_serializer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/n64_pkg.sv
// n64_pkg: shared types and constants for the N64-style serial transmitter.
// Holds the FSM state encoding and the 4-quarter line patterns for each symbol.
// Patterns are read MSB first in time: pattern[3] is quarter 0, pattern[0] is quarter 3.
package n64_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BIT  = 2'd1,
      STOP = 2'd2
   } n64_state_t;

   // Line levels for quarters 0..3, read from bit 3 down to bit 0.
   localparam logic [3:0] PAT_BIT0 = 4'b0001;
   localparam logic [3:0] PAT_BIT1 = 4'b0111;
   localparam logic [3:0] PAT_STOP = 4'b0111;

   // Line level of quarter q (0 = first in time) of a symbol pattern.
   function automatic logic quarter_level(input logic [3:0] pat, input logic [1:0] q);
      return pat[2'd3 - q];
   endfunction

   // Pattern for one payload bit.
   function automatic logic [3:0] bit_pattern(input logic b);
      return b ? PAT_BIT1 : PAT_BIT0;
   endfunction

endpackage

// File: rtl/n64_quarter_tick.sv
// n64_quarter_tick: quarter-slot strobe generator.
// Ports: clk, Reset (async, active-low), start (clears the count, used on accept),
//        run (count while a frame is active), slot_end (high in the last cycle of each slot).
module n64_quarter_tick
   import n64_pkg::*;
#(
   parameter int CLKS_PER_QUARTER = 12
) (
   input  logic clk,
   input  logic Reset,
   input  logic start,
   input  logic run,
   output logic slot_end
);

   localparam int TW = (CLKS_PER_QUARTER > 1) ? $clog2(CLKS_PER_QUARTER) : 1;
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_QUARTER - 1);

   logic [TW-1:0] tick;

   // With CLKS_PER_QUARTER == 1, LAST is 0 and every running cycle ends a slot.
   assign slot_end = run && (tick == LAST);

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         tick <= '0;
      end else if (start) begin
         tick <= '0;
      end else if (run) begin
         tick <= slot_end ? '0 : tick + TW'(1);
      end else begin
         tick <= '0;
      end
   end

endmodule

// File: rtl/n64_tx_serializer.sv
// n64_tx_serializer: sends up to DATA_W payload bits MSB-first plus an optional stop bit,
// each bit coded as four quarter slots of CLKS_PER_QUARTER clk cycles.
// Ports: clk, Reset (async, active-low); tx_data/tx_len/tx_stop/tx_valid request,
//        tx_ready (high only in IDLE); Data_Out serial line (idle high), busy, done pulse.
module n64_tx_serializer
   import n64_pkg::*;
#(
   parameter int DATA_W           = 8,
   parameter int CLKS_PER_QUARTER = 12
) (
   input  logic                        clk,
   input  logic                        Reset,
   input  logic [DATA_W-1:0]           tx_data,
   input  logic [$clog2(DATA_W+1)-1:0] tx_len,
   input  logic                        tx_stop,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        Data_Out,
   output logic                        busy,
   output logic                        done
);

   localparam int LW = $clog2(DATA_W + 1);

   n64_state_t        state;
   logic [1:0]        qcnt;
   logic [LW-1:0]     bits_left;
   logic [DATA_W-1:0] shreg;
   logic              stop_l;

   logic              accept;
   logic              run;
   logic              slot_end;
   logic [LW-1:0]     len_c;
   logic [DATA_W-1:0] shreg_nxt;
   logic [3:0]        cur_pat;

   assign accept    = tx_valid && tx_ready;
   assign run       = (state != IDLE);
   assign len_c     = (tx_len > LW'(DATA_W)) ? LW'(DATA_W) : tx_len;
   // The bit being sent is always the MSB of shreg; the next bit is shifted up into it.
   assign shreg_nxt = shreg << 1;

   always_comb begin
      cur_pat = PAT_STOP;
      if (state == BIT) begin
         cur_pat = bit_pattern(shreg[DATA_W-1]);
      end
   end

   n64_quarter_tick #(
      .CLKS_PER_QUARTER(CLKS_PER_QUARTER)
   ) u_tick (
      .clk     (clk),
      .Reset   (Reset),
      .start   (accept),
      .run     (run),
      .slot_end(slot_end)
   );

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         qcnt      <= 2'd0;
         bits_left <= '0;
         shreg     <= '0;
         stop_l    <= 1'b0;
         Data_Out  <= 1'b1;
         tx_ready  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg     <= tx_data;
                  stop_l    <= tx_stop;
                  bits_left <= len_c;
                  qcnt      <= 2'd0;
                  if (len_c != '0) begin
                     state    <= BIT;
                     Data_Out <= quarter_level(bit_pattern(tx_data[DATA_W-1]), 2'd0);
                     busy     <= 1'b1;
                     tx_ready <= 1'b0;
                  end else if (tx_stop) begin
                     state    <= STOP;
                     Data_Out <= quarter_level(PAT_STOP, 2'd0);
                     busy     <= 1'b1;
                     tx_ready <= 1'b0;
                  end else begin
                     // Empty frame: completes immediately, line never leaves idle.
                     done <= 1'b1;
                  end
               end
            end
            BIT, STOP: begin
               if (slot_end) begin
                  if (qcnt != 2'd3) begin
                     qcnt     <= qcnt + 2'd1;
                     Data_Out <= quarter_level(cur_pat, qcnt + 2'd1);
                  end else begin
                     qcnt <= 2'd0;
                     if ((state == BIT) && (bits_left > LW'(1))) begin
                        bits_left <= bits_left - LW'(1);
                        shreg     <= shreg_nxt;
                        Data_Out  <= quarter_level(bit_pattern(shreg_nxt[DATA_W-1]), 2'd0);
                     end else if ((state == BIT) && stop_l) begin
                        bits_left <= '0;
                        state     <= STOP;
                        Data_Out  <= quarter_level(PAT_STOP, 2'd0);
                     end else begin
                        // Frame end: the first IDLE cycle carries done with the line high.
                        bits_left <= '0;
                        state     <= IDLE;
                        Data_Out  <= 1'b1;
                        busy      <= 1'b0;
                        tx_ready  <= 1'b1;
                        done      <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state    <= IDLE;
               Data_Out <= 1'b1;
               busy     <= 1'b0;
               tx_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
